// File: rtl/npu_lane_serializer.sv
// rtl/npu_lane_serializer.sv - word FIFO feeding a byte-serial stream with 3x3 kernel group tags
// Words are stored {data3,data2,data1,data0} and drained lane 0 first, one byte per transfer.

module npu_lane_serializer #(
  parameter int DEPTH      = 4,
  parameter int GROUP_SIZE = 9
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [7:0]               data0_i,
  input  logic [7:0]               data1_i,
  input  logic [7:0]               data2_i,
  input  logic [7:0]               data3_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [7:0]               out_data_o,
  output logic                     out_first_o,
  output logic                     out_last_o,
  input  logic                     group_clear_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] GLAST = 8'(GROUP_SIZE - 1);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic        full, empty, push, xfer, pop;
  logic [31:0] head;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    push  = in_valid_i && !full;
    xfer  = !empty && out_ready_i;
    pop   = xfer && (lane_q == 2'd3);
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    lane_d = lane_q;
    gcnt_d = gcnt_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    if (xfer) lane_d = lane_q + 2'd1;
    // A clear wins over the increment of a transfer in the same cycle.
    if (group_clear_i) begin
      gcnt_d = 8'd0;
    end else if (xfer) begin
      gcnt_d = (gcnt_q == GLAST) ? 8'd0 : gcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lane_q <= 2'd0;
      gcnt_q <= 8'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lane_q <= lane_d;
      gcnt_q <= gcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {data3_i, data2_i, data1_i, data0_i};
    end
  end

  always_comb begin
    head = mem_q[rptr_q[AW-1:0]];
    case (lane_q)
      2'd0:    out_data_o = head[7:0];
      2'd1:    out_data_o = head[15:8];
      2'd2:    out_data_o = head[23:16];
      default: out_data_o = head[31:24];
    endcase
  end

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign out_first_o = !empty && (gcnt_q == 8'd0);
  assign out_last_o  = !empty && (gcnt_q == GLAST);
  assign level_o     = wptr_q - rptr_q;

endmodule

// File: tb/tb_npu_lane_serializer.sv
// tb/tb_npu_lane_serializer.sv - directed self-checking bench for npu_lane_serializer
module tb_npu_lane_serializer;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] data0_i = 8'h0, data1_i = 8'h0, data2_i = 8'h0, data3_i = 8'h0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [7:0] out_data_o;
  logic       out_first_o, out_last_o;
  logic       group_clear_i = 1'b0;
  logic [2:0] level_o;

  int n_cmp = 0;
  int n_bad = 0;

  npu_lane_serializer #(.DEPTH(4), .GROUP_SIZE(9)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i), .data3_i(data3_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_first_o(out_first_o), .out_last_o(out_last_o), .group_clear_i(group_clear_i),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; group_clear_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic set_word(input logic [31:0] w);
    {data3_i, data2_i, data1_i, data0_i} = w;
  endtask

  task automatic push_word(input logic [31:0] w);
    set_word(w);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
    n_cmp++; if (out_first_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_first got %b want 0", out_first_o); end
    n_cmp++; if (out_last_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", out_last_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
    n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level_o); end
    n_cmp++; if (out_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", out_data_o); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    do_reset();
    out_ready_i = 1'b1;
    push_word(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid[%0d] got %b want 1", i, out_valid_o); end
      n_cmp++; if (out_data_o !== exp_b[i]) begin n_bad++; $display("FAIL single_data[%0d] got %h want %h", i, out_data_o, exp_b[i]); end
      n_cmp++; if (out_first_o !== (i == 0)) begin n_bad++; $display("FAIL single_first[%0d] got %b want %b", i, out_first_o, (i == 0)); end
      n_cmp++; if (level_o !== 3'd1) begin n_bad++; $display("FAIL single_level[%0d] got %0d want 1", i, level_o); end
      tick();
    end
    n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("FAIL single_level_end got %0d want 0", level_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_valid_end got %b want 0", out_valid_o); end
  endtask

  task automatic test_group_across();
    do_reset();
    push_word(32'h03020100);
    push_word(32'h07060504);
    push_word(32'h0B0A0908);
    n_cmp++; if (level_o !== 3'd3) begin n_bad++; $display("FAIL group_level got %0d want 3", level_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (out_data_o !== 8'(i)) begin n_bad++; $display("FAIL group_data[%0d] got %h want %h", i, out_data_o, 8'(i)); end
      n_cmp++; if (out_first_o !== (i == 0 || i == 9)) begin n_bad++; $display("FAIL group_first[%0d] got %b", i, out_first_o); end
      n_cmp++; if (out_last_o !== (i == 8)) begin n_bad++; $display("FAIL group_last[%0d] got %b", i, out_last_o); end
      tick();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_full_backpressure();
    logic [31:0] w [5];
    int got;
    bit accepted;
    for (int k = 0; k < 5; k++) w[k] = {8'(16*k+3), 8'(16*k+2), 8'(16*k+1), 8'(16*k)};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL full_fill_ready[%0d] got %b want 1", k, in_ready_o); end
      push_word(w[k]);
    end
    set_word(w[4]);
    in_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_hold_ready[%0d] got %b want 0", c, in_ready_o); end
      n_cmp++; if (level_o !== 3'd4) begin n_bad++; $display("FAIL full_hold_level[%0d] got %0d want 4", c, level_o); end
      tick();
    end
    out_ready_i = 1'b1;
    got = 0;
    accepted = 1'b0;
    for (int c = 0; c < 40 && got < 20; c++) begin
      if (in_valid_i) begin
        n_cmp++; if (in_ready_o !== (got == 4)) begin n_bad++; $display("FAIL full_ready_at_byte%0d got %b want %b", got, in_ready_o, (got == 4)); end
        if (in_ready_o) accepted = 1'b1;
      end
      if (out_valid_o) begin
        n_cmp++; if (out_data_o !== 8'(16*(got/4) + got%4)) begin n_bad++; $display("FAIL full_order[%0d] got %h want %h", got, out_data_o, 8'(16*(got/4) + got%4)); end
        got++;
      end
      tick();
      if (accepted) in_valid_i = 1'b0;
    end
    n_cmp++; if (got !== 20) begin n_bad++; $display("FAIL full_byte_count got %0d want 20", got); end
    n_cmp++; if (accepted !== 1'b1) begin n_bad++; $display("FAIL full_fifth_accepted got %b want 1", accepted); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL full_drained got %b want 0", out_valid_o); end
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    logic [2:0] exp_lvl [5];
    logic       exp_rdy [5];
    exp_lvl[0] = 3'd4; exp_lvl[1] = 3'd4; exp_lvl[2] = 3'd4; exp_lvl[3] = 3'd3; exp_lvl[4] = 3'd4;
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b1; exp_rdy[4] = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) push_word(32'hA0A0A0A0 + 32'(k));
    set_word(32'hB3B2B1B0);
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (level_o !== exp_lvl[c]) begin n_bad++; $display("FAIL simul_level[%0d] got %0d want %0d", c, level_o, exp_lvl[c]); end
      n_cmp++; if (in_ready_o !== exp_rdy[c]) begin n_bad++; $display("FAIL simul_ready[%0d] got %b want %b", c, in_ready_o, exp_rdy[c]); end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_word(32'hD3D2D1D0);
    push_word(32'hD7D6D5D4);
    out_ready_i = 1'b1;
    tick();
    tick();
    n_cmp++; if (out_data_o !== 8'hD2) begin n_bad++; $display("FAIL midrst_pre_data got %h want d2", out_data_o); end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", out_valid_o); end
    n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("FAIL midrst_level got %0d want 0", level_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", in_ready_o); end
    out_ready_i = 1'b0;
    push_word(32'hE3E2E1E0);
    n_cmp++; if (out_data_o !== 8'hE0) begin n_bad++; $display("FAIL midrst_new_data got %h want e0", out_data_o); end
    n_cmp++; if (out_first_o !== 1'b1) begin n_bad++; $display("FAIL midrst_new_first got %b want 1", out_first_o); end
    n_cmp++; if (level_o !== 3'd1) begin n_bad++; $display("FAIL midrst_new_level got %0d want 1", level_o); end
  endtask

  task automatic test_group_clear();
    do_reset();
    for (int k = 0; k < 4; k++)
      push_word({8'(8'h53 + 4*k), 8'(8'h52 + 4*k), 8'(8'h51 + 4*k), 8'(8'h50 + 4*k)});
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (out_data_o !== 8'h55) begin n_bad++; $display("FAIL gclr_pre_data got %h want 55", out_data_o); end
    n_cmp++; if (out_first_o !== 1'b0) begin n_bad++; $display("FAIL gclr_pre_first got %b want 0", out_first_o); end
    group_clear_i = 1'b1;
    tick();
    group_clear_i = 1'b0;
    for (int j = 0; j < 9; j++) begin
      n_cmp++; if (out_data_o !== 8'(8'h56 + j)) begin n_bad++; $display("FAIL gclr_data[%0d] got %h want %h", j, out_data_o, 8'(8'h56 + j)); end
      n_cmp++; if (out_first_o !== (j == 0)) begin n_bad++; $display("FAIL gclr_first[%0d] got %b want %b", j, out_first_o, (j == 0)); end
      n_cmp++; if (out_last_o !== (j == 8)) begin n_bad++; $display("FAIL gclr_last[%0d] got %b want %b", j, out_last_o, (j == 8)); end
      tick();
    end
    out_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_group_across();
    test_full_backpressure();
    test_simul_push_pop();
    test_reset_mid();
    test_group_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
